// File: rtl/dat_rx_phys.sv
// -----------------------------------------------------------------------------
// dat_rx_phys -- receive half of the SD DAT physical layer.
//
// Waits for the card's start nibble (4'h0) on DAT[3:0], shifts in data nibbles
// MSB-first, packs them into FIFO_WIDTH words for the Rx FIFO, checks the
// per-line CRC16 and the end nibble of every block, and repeats for block_cnt
// blocks.
//
// Ports:
//   sd_clk          block clock, rising edge
//   rst             synchronous reset, active-high
//   DAT_din         DAT[3:0] from the card, sampled every edge
//   block_sz        bytes per block, latched at start
//   block_cnt       number of blocks, latched at start
//   read_flag       start request, honoured only when idle
//   rx_buf_full     Rx FIFO full
//   rx_buf_wr_enb   one-cycle Rx FIFO write strobe
//   rx_buf_din_out  assembled word, valid while rx_buf_wr_enb=1
//   rx_busy         high while a transfer is in progress
//   tf_finished     pulse: all blocks received cleanly
//   crc_err         pulse: CRC16 mismatch on any line
//   end_bit_err     pulse: end nibble was not 4'hF
//   timeout_err     pulse: no start nibble within TIMEOUT_CYCLES
//   overrun_err     pulse: word completed while the Rx FIFO was full
// -----------------------------------------------------------------------------
module dat_rx_phys #(
  parameter int FIFO_WIDTH      = 32,
  parameter int BLOCK_SZ_WIDTH  = 12,
  parameter int BLOCK_CNT_WIDTH = 16,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       sd_clk,
  input  logic                       rst,
  input  logic [3:0]                 DAT_din,
  input  logic [BLOCK_SZ_WIDTH-1:0]  block_sz,
  input  logic [BLOCK_CNT_WIDTH-1:0] block_cnt,
  input  logic                       read_flag,
  input  logic                       rx_buf_full,
  output logic                       rx_buf_wr_enb,
  output logic [FIFO_WIDTH-1:0]      rx_buf_din_out,
  output logic                       rx_busy,
  output logic                       tf_finished,
  output logic                       crc_err,
  output logic                       end_bit_err,
  output logic                       timeout_err,
  output logic                       overrun_err
);

  localparam int NIB_PER_WORD = FIFO_WIDTH / 4;
  localparam int WNIB_W       = (NIB_PER_WORD > 1) ? $clog2(NIB_PER_WORD) : 1;
  // One extra bit: a block holds block_sz*2 nibbles.
  localparam int BNIB_W       = BLOCK_SZ_WIDTH + 1;
  localparam int TMO_W        = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [WNIB_W-1:0] WNIB_LAST = WNIB_W'(NIB_PER_WORD - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BNIB_W-1:0] CRC_LAST  = BNIB_W'(15);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_DATA,
    S_CRC,
    S_END
  } state_t;

  // CRC16 (x^16+x^12+x^5+1), one bit, MSB-first.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    crc16_step = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  state_t                      state_q, state_d;
  logic [BLOCK_SZ_WIDTH-1:0]   blk_sz_q, blk_sz_d;
  logic [BLOCK_CNT_WIDTH-1:0]  blk_left_q, blk_left_d;
  logic [TMO_W-1:0]            tmo_q, tmo_d;
  // Nibble index within the block in DATA, reused as the CRC nibble index.
  logic [BNIB_W-1:0]           bnib_q, bnib_d;
  logic [WNIB_W-1:0]           wnib_q, wnib_d;
  // Only the first NIB_PER_WORD-1 nibbles are stored; the last is taken live.
  logic [FIFO_WIDTH-5:0]       shift_q, shift_d;
  logic [3:0][15:0]            crc_q, crc_d;
  logic                        crc_bad_q, crc_bad_d;

  logic                        wr_enb_q, wr_enb_d;
  logic [FIFO_WIDTH-1:0]       din_out_q, din_out_d;
  logic                        busy_q, busy_d;
  logic                        tf_q, tf_d;
  logic                        crc_err_q, crc_err_d;
  logic                        end_err_q, end_err_d;
  logic                        tmo_err_q, tmo_err_d;
  logic                        ovr_q, ovr_d;

  logic [FIFO_WIDTH-1:0]       word_d;
  logic [BNIB_W-1:0]           blk_last;
  logic [3:0]                  crc_msb;

  assign blk_last = {blk_sz_q, 1'b0} - BNIB_W'(1);

  always_comb begin
    state_d    = state_q;
    blk_sz_d   = blk_sz_q;
    blk_left_d = blk_left_q;
    tmo_d      = tmo_q;
    bnib_d     = bnib_q;
    wnib_d     = wnib_q;
    shift_d    = shift_q;
    crc_d      = crc_q;
    crc_bad_d  = crc_bad_q;
    wr_enb_d   = 1'b0;
    din_out_d  = din_out_q;
    tf_d       = 1'b0;
    crc_err_d  = 1'b0;
    end_err_d  = 1'b0;
    tmo_err_d  = 1'b0;
    ovr_d      = 1'b0;
    word_d     = {shift_q, DAT_din};
    crc_msb    = 4'h0;

    case (state_q)
      S_IDLE: begin
        if (read_flag) begin
          if (block_cnt != '0) begin
            blk_sz_d   = block_sz;
            blk_left_d = block_cnt;
            tmo_d      = '0;
            state_d    = S_WAIT_START;
          end else begin
            tf_d = 1'b1;
          end
        end
      end

      S_WAIT_START: begin
        if (DAT_din == 4'h0) begin
          crc_d     = '0;
          crc_bad_d = 1'b0;
          bnib_d    = '0;
          wnib_d    = '0;
          state_d   = S_DATA;
        end else if (tmo_q == TMO_LAST) begin
          // This is the TIMEOUT_CYCLES-th edge without a start nibble.
          tmo_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_DATA: begin
        shift_d = word_d[FIFO_WIDTH-5:0];
        for (int i = 0; i < 4; i++) begin
          crc_d[i] = crc16_step(crc_q[i], DAT_din[i]);
        end
        bnib_d = bnib_q + BNIB_W'(1);
        wnib_d = (wnib_q == WNIB_LAST) ? '0 : wnib_q + WNIB_W'(1);
        if ((wnib_q == WNIB_LAST) && rx_buf_full) begin
          ovr_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          if (wnib_q == WNIB_LAST) begin
            wr_enb_d  = 1'b1;
            din_out_d = word_d;
          end
          if (bnib_q == blk_last) begin
            bnib_d  = '0;
            state_d = S_CRC;
          end
        end
      end

      S_CRC: begin
        // Compare each received CRC bit against the computed MSB as it
        // arrives, then shift the computed CRC so the next bit lines up.
        for (int i = 0; i < 4; i++) begin
          crc_msb[i] = crc_q[i][15];
          crc_d[i]   = {crc_q[i][14:0], 1'b0};
        end
        crc_bad_d = crc_bad_q | (|(DAT_din ^ crc_msb));
        bnib_d    = bnib_q + BNIB_W'(1);
        if (bnib_q == CRC_LAST) begin
          state_d = S_END;
        end
      end

      S_END: begin
        if (crc_bad_q) begin
          crc_err_d = 1'b1;
          state_d   = S_IDLE;
        end else if (DAT_din != 4'hF) begin
          end_err_d = 1'b1;
          state_d   = S_IDLE;
        end else if (blk_left_q == BLOCK_CNT_WIDTH'(1)) begin
          blk_left_d = '0;
          tf_d       = 1'b1;
          state_d    = S_IDLE;
        end else begin
          blk_left_d = blk_left_q - BLOCK_CNT_WIDTH'(1);
          tmo_d      = '0;
          state_d    = S_WAIT_START;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge sd_clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      blk_sz_q   <= '0;
      blk_left_q <= '0;
      tmo_q      <= '0;
      bnib_q     <= '0;
      wnib_q     <= '0;
      shift_q    <= '0;
      crc_q      <= '0;
      crc_bad_q  <= 1'b0;
      wr_enb_q   <= 1'b0;
      din_out_q  <= '0;
      busy_q     <= 1'b0;
      tf_q       <= 1'b0;
      crc_err_q  <= 1'b0;
      end_err_q  <= 1'b0;
      tmo_err_q  <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      blk_sz_q   <= blk_sz_d;
      blk_left_q <= blk_left_d;
      tmo_q      <= tmo_d;
      bnib_q     <= bnib_d;
      wnib_q     <= wnib_d;
      shift_q    <= shift_d;
      crc_q      <= crc_d;
      crc_bad_q  <= crc_bad_d;
      wr_enb_q   <= wr_enb_d;
      din_out_q  <= din_out_d;
      busy_q     <= busy_d;
      tf_q       <= tf_d;
      crc_err_q  <= crc_err_d;
      end_err_q  <= end_err_d;
      tmo_err_q  <= tmo_err_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_buf_wr_enb  = wr_enb_q;
  assign rx_buf_din_out = din_out_q;
  assign rx_busy        = busy_q;
  assign tf_finished    = tf_q;
  assign crc_err        = crc_err_q;
  assign end_bit_err    = end_err_q;
  assign timeout_err    = tmo_err_q;
  assign overrun_err    = ovr_q;

endmodule

// File: tb/tb_dat_rx_phys.sv
// -----------------------------------------------------------------------------
// tb_dat_rx_phys -- directed bench for dat_rx_phys (FIFO_WIDTH=32,
// TIMEOUT_CYCLES=16). Card traffic is generated by tasks; per-line CRCs come
// from a bench CRC16 function.
// -----------------------------------------------------------------------------
module tb_dat_rx_phys;

  logic        sd_clk = 1'b0;
  logic        rst;
  logic [3:0]  DAT_din;
  logic [11:0] block_sz;
  logic [15:0] block_cnt;
  logic        read_flag;
  logic        rx_buf_full;
  logic        rx_buf_wr_enb;
  logic [31:0] rx_buf_din_out;
  logic        rx_busy;
  logic        tf_finished;
  logic        crc_err;
  logic        end_bit_err;
  logic        timeout_err;
  logic        overrun_err;

  dat_rx_phys #(
    .FIFO_WIDTH      (32),
    .BLOCK_SZ_WIDTH  (12),
    .BLOCK_CNT_WIDTH (16),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .sd_clk         (sd_clk),
    .rst            (rst),
    .DAT_din        (DAT_din),
    .block_sz       (block_sz),
    .block_cnt      (block_cnt),
    .read_flag      (read_flag),
    .rx_buf_full    (rx_buf_full),
    .rx_buf_wr_enb  (rx_buf_wr_enb),
    .rx_buf_din_out (rx_buf_din_out),
    .rx_busy        (rx_busy),
    .tf_finished    (tf_finished),
    .crc_err        (crc_err),
    .end_bit_err    (end_bit_err),
    .timeout_err    (timeout_err),
    .overrun_err    (overrun_err)
  );

  always #5 sd_clk = ~sd_clk;

  int vec_cnt = 0;
  int miscmp  = 0;

  int wr_total = 0;
  int tf_cnt   = 0;
  int crc_cnt  = 0;
  int eb_cnt   = 0;
  int to_cnt   = 0;
  int ov_cnt   = 0;
  int excl_viol = 0;
  int busy_drop = 0;
  bit track_busy = 1'b0;

  logic [31:0] blk_words [0:6];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscmp++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc16_bit(input logic [15:0] c, input logic b);
    logic [15:0] n;
    n = c << 1;
    if (c[15] != b) n = n ^ 16'h1021;
    return n;
  endfunction

  // Advance one edge and sample outputs 1 time unit later.
  task automatic step();
    @(posedge sd_clk);
    #1;
    if (rx_buf_wr_enb) wr_total++;
    if (tf_finished)   tf_cnt++;
    if (crc_err)       crc_cnt++;
    if (end_bit_err)   eb_cnt++;
    if (timeout_err)   to_cnt++;
    if (overrun_err)   ov_cnt++;
    if ($countones({tf_finished, crc_err, end_bit_err, timeout_err, overrun_err}) > 1)
      excl_viol++;
    if (track_busy && !rx_busy) busy_drop++;
  endtask

  task automatic start_read(input logic [11:0] sz, input logic [15:0] cnt);
    block_sz  = sz;
    block_cnt = cnt;
    read_flag = 1'b1;
    step();
    read_flag = 1'b0;
  endtask

  // Start nibble, nw data words, 16 CRC nibbles, end nibble. flip_line/flip_k
  // corrupt one CRC bit; ovr raises rx_buf_full as the first word completes.
  task automatic send_block(input int base, input int nw, input int flip_line,
                            input int flip_k, input logic [3:0] end_nib, input bit ovr);
    logic [3:0][15:0] crc;
    logic [31:0]      w;
    logic [3:0]       nib;
    bit               save;
    crc = '0;
    DAT_din = 4'h0;
    step();
    for (int i = 0; i < nw; i++) begin
      w = blk_words[base + i];
      for (int j = 0; j < 8; j++) begin
        nib = w[31 - 4*j -: 4];
        for (int l = 0; l < 4; l++) crc[l] = crc16_bit(crc[l], nib[l]);
        DAT_din = nib;
        if (ovr && j == 7) rx_buf_full = 1'b1;
        step();
        if (j == 7) begin
          if (ovr) begin
            check("ovr_pulse", 32'(overrun_err), 32'd1);
            check("ovr_no_wr", 32'(rx_buf_wr_enb), 32'd0);
            check("ovr_idle", 32'(rx_busy), 32'd0);
            rx_buf_full = 1'b0;
            return;
          end
          check("wr_stb", 32'(rx_buf_wr_enb), 32'd1);
          check("wr_word", rx_buf_din_out, w);
        end
      end
    end
    for (int k = 0; k < 16; k++) begin
      for (int l = 0; l < 4; l++) begin
        nib[l] = crc[l][15 - k];
        if (l == flip_line && k == flip_k) nib[l] = ~nib[l];
      end
      DAT_din = nib;
      step();
    end
    save = track_busy;
    track_busy = 1'b0;
    DAT_din = end_nib;
    step();
    track_busy = save;
  endtask

  int wr0, tf0;

  initial begin
    blk_words[0] = 32'hDEADBEEF;
    blk_words[1] = 32'h01234567;
    blk_words[2] = 32'h89ABCDEF;
    blk_words[3] = 32'hA5A55A5A;
    blk_words[4] = 32'hFFFF0000;
    blk_words[5] = 32'h0000FFFF;
    blk_words[6] = 32'h13579BDF;

    rst = 1'b1; read_flag = 1'b0; DAT_din = 4'hF; rx_buf_full = 1'b0;
    block_sz = 12'd4; block_cnt = 16'd1;
    step(); step();
    check("rst_ctl", 32'({rx_buf_wr_enb, rx_busy, tf_finished, crc_err, end_bit_err,
                          timeout_err, overrun_err}), 32'd0);
    check("rst_din", rx_buf_din_out, 32'd0);
    rst = 1'b0;
    step();

    // Single clean block.
    start_read(12'd4, 16'd1);
    check("rd_busy", 32'(rx_busy), 32'd1);
    DAT_din = 4'hF; step(); step();
    wr0 = wr_total; tf0 = tf_cnt;
    send_block(0, 1, -1, 0, 4'hF, 1'b0);
    check("t1_tf", 32'(tf_finished), 32'd1);
    check("t1_idle", 32'(rx_busy), 32'd0);
    check("t1_nwr", 32'(wr_total - wr0), 32'd1);
    step();
    check("t1_tf_once", 32'(tf_finished), 32'd0);

    // Three blocks of two words.
    start_read(12'd8, 16'd3);
    track_busy = 1'b1;
    wr0 = wr_total; tf0 = tf_cnt;
    for (int b = 0; b < 3; b++) begin
      DAT_din = 4'hF;
      if (b > 0) begin
        repeat (4) step();
      end else begin
        step();
      end
      send_block(1 + 2*b, 2, -1, 0, 4'hF, 1'b0);
      if (b < 2) check("mb_tf_mid", 32'(tf_finished), 32'd0);
    end
    track_busy = 1'b0;
    check("mb_tf", 32'(tf_finished), 32'd1);
    check("mb_ntf", 32'(tf_cnt - tf0), 32'd1);
    check("mb_nwr", 32'(wr_total - wr0), 32'd6);
    check("mb_busy", 32'(busy_drop), 32'd0);
    DAT_din = 4'hF; step();

    // CRC corruption on line 2, block 1 of 2.
    start_read(12'd4, 16'd2);
    DAT_din = 4'hF; step();
    send_block(0, 1, 2, 5, 4'hF, 1'b0);
    check("crc_pulse", 32'(crc_err), 32'd1);
    check("crc_idle", 32'(rx_busy), 32'd0);
    check("crc_no_tf", 32'(tf_finished), 32'd0);
    wr0 = wr_total; tf0 = tf_cnt;
    DAT_din = 4'hF; repeat (4) step();
    DAT_din = 4'h0; step();
    for (int i = 0; i < 26; i++) begin
      DAT_din = 4'(i);
      step();
    end
    DAT_din = 4'hF; step();
    check("crc_no_blk2", 32'(wr_total - wr0), 32'd0);
    check("crc_no_tf2", 32'(tf_cnt - tf0), 32'd0);
    check("crc_stay_idle", 32'(rx_busy), 32'd0);

    // Start timeout.
    start_read(12'd4, 16'd1);
    DAT_din = 4'hF;
    repeat (15) step();
    check("to_early", 32'(timeout_err), 32'd0);
    check("to_busy", 32'(rx_busy), 32'd1);
    step();
    check("to_pulse", 32'(timeout_err), 32'd1);
    check("to_idle", 32'(rx_busy), 32'd0);
    step();
    check("to_clear", 32'(timeout_err), 32'd0);

    // Bad end nibble.
    start_read(12'd4, 16'd1);
    DAT_din = 4'hF; step();
    send_block(0, 1, -1, 0, 4'h7, 1'b0);
    check("eb_pulse", 32'(end_bit_err), 32'd1);
    check("eb_no_crc", 32'(crc_err), 32'd0);
    check("eb_no_tf", 32'(tf_finished), 32'd0);
    DAT_din = 4'hF; step();

    // Overrun on the first word.
    wr0 = wr_total;
    start_read(12'd4, 16'd1);
    DAT_din = 4'hF; step();
    send_block(0, 1, -1, 0, 4'hF, 1'b1);
    DAT_din = 4'hF; step();
    check("ovr_clear", 32'(overrun_err), 32'd0);
    check("ovr_nwr", 32'(wr_total - wr0), 32'd0);

    // Reset after three data nibbles, then a fresh read.
    start_read(12'd4, 16'd1);
    DAT_din = 4'h0; step();
    DAT_din = 4'hD; step();
    DAT_din = 4'hE; step();
    DAT_din = 4'hA; step();
    rst = 1'b1; DAT_din = 4'hD;
    step();
    check("mid_rst_ctl", 32'({rx_buf_wr_enb, rx_busy, tf_finished, crc_err, end_bit_err,
                              timeout_err, overrun_err}), 32'd0);
    check("mid_rst_din", rx_buf_din_out, 32'd0);
    rst = 1'b0; DAT_din = 4'hF;
    step();
    check("mid_rst_idle", 32'(rx_busy), 32'd0);
    wr0 = wr_total;
    start_read(12'd4, 16'd1);
    DAT_din = 4'hF; step();
    send_block(0, 1, -1, 0, 4'hF, 1'b0);
    check("fresh_tf", 32'(tf_finished), 32'd1);
    check("fresh_nwr", 32'(wr_total - wr0), 32'd1);
    DAT_din = 4'hF; step();

    // Zero block count.
    start_read(12'd4, 16'd0);
    check("zero_tf", 32'(tf_finished), 32'd1);
    check("zero_idle", 32'(rx_busy), 32'd0);
    step();
    check("zero_tf_once", 32'(tf_finished), 32'd0);

    // Totals over the whole run.
    check("tot_tf", 32'(tf_cnt), 32'd4);
    check("tot_crc", 32'(crc_cnt), 32'd1);
    check("tot_eb", 32'(eb_cnt), 32'd1);
    check("tot_to", 32'(to_cnt), 32'd1);
    check("tot_ov", 32'(ov_cnt), 32'd1);
    check("excl", 32'(excl_viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule

// File: doc/dat_rx_phys.md
Name: dat_rx_phys

Overview:
- Receive half of the SD DAT physical layer: the counterpart of the DAT write path.
- Waits for the card's start bit on DAT[3:0], shifts in 4-bit nibbles MSB-first, and packs them into FIFO_WIDTH words written to the Rx FIFO.
- Checks the per-line CRC16 and the end bit of every block, and repeats for block_cnt blocks.
- Sits between the SD pads and the Rx FIFO, alongside the DAT transmit path, and is started by the DAT control logic.

Parameters:
- FIFO_WIDTH, 32, Rx FIFO word width in bits; multiple of 8.
- BLOCK_SZ_WIDTH, 12, width of block_sz (bytes per block).
- BLOCK_CNT_WIDTH, 16, width of block_cnt.
- TIMEOUT_CYCLES, 1024, maximum sd_clk cycles to wait for a start bit; counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- sd_clk  in  1  single clock for the block; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- DAT_din  in  4  DAT lines from the card, sampled every sd_clk edge.
- block_sz  in  BLOCK_SZ_WIDTH  bytes per block; latched at start.
- block_cnt  in  BLOCK_CNT_WIDTH  number of blocks; latched at start.
- read_flag  in  1  start request; honoured only in IDLE.
- rx_buf_full  in  1  Rx FIFO full.
- rx_buf_wr_enb  out  1  one-cycle write strobe to the Rx FIFO.
- rx_buf_din_out  out  FIFO_WIDTH  assembled word; valid while rx_buf_wr_enb=1.
- rx_busy  out  1  high whenever state != IDLE.
- tf_finished  out  1  one-cycle pulse when all blocks are received cleanly.
- crc_err  out  1  one-cycle pulse on a CRC16 mismatch on any line.
- end_bit_err  out  1  one-cycle pulse when the end nibble != 4'hF.
- timeout_err  out  1  one-cycle pulse when no start bit arrives in time.
- overrun_err  out  1  one-cycle pulse when a word completes while rx_buf_full=1.

Behaviour:
- Reset: synchronous and active-high, so it takes effect at the sd_clk edge where rst=1.
  - All outputs go to 0 and state goes to IDLE.
  - Counters, CRC registers and the shift register clear.
  - Reset mid-transfer aborts immediately; no error or finished pulse is produced.
- All outputs are registered.
- States: IDLE, WAIT_START, DATA, CRC, END.
- IDLE:
  - On read_flag=1 with block_cnt!=0: latch block_sz and block_cnt, clear the timeout counter, go to WAIT_START.
  - On read_flag=1 with block_cnt==0: pulse tf_finished and stay in IDLE.
- WAIT_START:
  - DAT_din==4'h0 is the start bit: clear all four CRC16 registers and the nibble counters, go to DATA.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT_CYCLES, pulse timeout_err and go to IDLE.
- DATA:
  - Block length is block_sz*2 nibbles. block_sz must be a nonzero multiple of FIFO_WIDTH/8; other values are undefined.
  - Each edge shifts DAT_din into the word. The first nibble of a word lands in bits [FIFO_WIDTH-1 -: 4].
  - Each edge also updates CRC line i with DAT_din[i]. Polynomial is x^16+x^12+x^5+1, init 0, MSB-first.
  - On the edge that samples the last nibble of a word:
    - If rx_buf_full=0: rx_buf_din_out gets the full word and rx_buf_wr_enb=1 for exactly the next cycle.
    - If rx_buf_full=1: pulse overrun_err, drop the word, go to IDLE.
  - After the last data nibble, go to CRC.
- CRC:
  - Sample 16 nibbles. Bit i of each nibble is the next MSB-first bit of the received CRC for line i.
  - After the 16th nibble, compare all four lines against the computed values and go to END.
- END:
  - Sample DAT_din.
  - If a CRC mismatched: pulse crc_err and go to IDLE. crc_err takes precedence over end_bit_err.
  - Else if DAT_din!=4'hF: pulse end_bit_err and go to IDLE.
  - Else decrement the remaining block count:
    - If more blocks remain: clear the timeout counter and go to WAIT_START.
    - If none remain: pulse tf_finished and go to IDLE.
- Latency for a single-word block with start bit sampled at edge t0:
  - Nibbles are sampled at t1..t(W/4).
  - rx_buf_wr_enb is high in the cycle after t(W/4).
  - CRC occupies t(W/4+1)..t(W/4+16); end nibble at t(W/4+17).
  - tf_finished is high in the cycle after t(W/4+17).
- read_flag is ignored outside IDLE.
- Error outputs and tf_finished are mutually exclusive and never high together.

Test Plan:
- Single block, clean:
  - Stimulus: block_sz=4, block_cnt=1, start nibble 0, data nibbles D,E,A,D,B,E,E,F, correct per-line CRCs, end nibble F.
  - Response: one write of 0xDEADBEEF; tf_finished one cycle after the end nibble; no errors.
- Multi-block:
  - Stimulus: block_sz=8, block_cnt=3, 4 cycles of DAT_din=4'hF between blocks.
  - Response: 6 writes in order; rx_busy stays high throughout; exactly one tf_finished, after block 3.
- CRC corruption:
  - Stimulus: flip one bit of the line-2 CRC in block 1 of 2.
  - Response: crc_err pulse; return to IDLE; no tf_finished; block 2 is not received.
- Start timeout:
  - Stimulus: DAT_din held at 4'hF with TIMEOUT_CYCLES=16.
  - Response: timeout_err pulses after 16 cycles in WAIT_START.
- End bit and overrun:
  - Stimulus: end nibble 4'h7.
    - Response: end_bit_err.
  - Stimulus: rx_buf_full=1 when the word completes.
    - Response: overrun_err, and no rx_buf_wr_enb.
- Reset mid-DATA and zero-count start:
  - Stimulus: rst=1 after 3 data nibbles.
    - Response: next cycle all outputs 0 and state IDLE; a fresh read then works normally.
  - Stimulus: read_flag with block_cnt=0.
    - Response: immediate tf_finished.
